// File: rtl/cbfp1_shift_detect.sv
// CBFP stage-1 block-exponent detector: buffers blocks of complex samples in
// ping-pong banks and replays each block tagged with its minimum redundant-sign-bit count.
module cbfp1_shift_detect #(
  parameter int unsigned INPUT_WIDTH = 25,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned BLOCK_LEN   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [INPUT_WIDTH-1:0] in_re,
  input  logic [INPUT_WIDTH-1:0] in_im,
  output logic                   out_valid,
  output logic [INPUT_WIDTH-1:0] out_re,
  output logic [INPUT_WIDTH-1:0] out_im,
  output logic [SHIFT_WIDTH-1:0] out_shift,
  output logic                   out_first,
  output logic                   out_last
);

  localparam int unsigned CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);
  localparam logic [SHIFT_WIDTH-1:0] RSB_MAX = SHIFT_WIDTH'(INPUT_WIDTH - 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  // Redundant sign bits: run of bits directly below the MSB that equal the MSB.
  function automatic logic [SHIFT_WIDTH-1:0] rsb(input logic [INPUT_WIDTH-1:0] x);
    logic [INPUT_WIDTH-1:0] t;
    logic                   done;
    int unsigned            n;
    done = 1'b0;
    n    = 0;
    for (int unsigned i = 1; i < INPUT_WIDTH; i++) begin
      t = x << i;
      if (!done && (t[INPUT_WIDTH-1] == x[INPUT_WIDTH-1])) n++;
      else done = 1'b1;
    end
    return SHIFT_WIDTH'(n);
  endfunction

  logic [2*INPUT_WIDTH-1:0] mem [2*BLOCK_LEN];

  logic [CNT_W-1:0]       wr_cnt;
  logic                   wr_bank;
  logic [SHIFT_WIDTH-1:0] run_min;
  logic [CNT_W-1:0]       rd_cnt;
  logic                   rd_bank;
  logic [SHIFT_WIDTH-1:0] rd_shift;
  state_t                 state, state_next;
  logic                   rd_start;

  logic [SHIFT_WIDTH-1:0] rsb_re, rsb_im, smp_min, blk_min;
  logic                   blk_done;
  logic [2*INPUT_WIDTH-1:0] rd_word;

  assign rsb_re   = rsb(in_re);
  assign rsb_im   = rsb(in_im);
  assign smp_min  = (rsb_re < rsb_im) ? rsb_re : rsb_im;
  assign blk_min  = (smp_min < run_min) ? smp_min : run_min;
  assign blk_done = in_valid && (wr_cnt == LAST);
  assign rd_word  = mem[{rd_bank, rd_cnt}];

  always_ff @(posedge clk) begin
    if (in_valid) mem[{wr_bank, wr_cnt}] <= {in_re, in_im};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      run_min <= RSB_MAX;
    end else if (in_valid) begin
      if (blk_done) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
        run_min <= RSB_MAX;
      end else begin
        wr_cnt  <= wr_cnt + 1'b1;
        run_min <= blk_min;
      end
    end
  end

  always_comb begin
    state_next = state;
    rd_start   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (blk_done) begin
          state_next = S_READ;
          rd_start   = 1'b1;
        end
      end
      S_READ: begin
        if (rd_cnt == LAST) begin
          if (blk_done) rd_start = 1'b1;
          else          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The exponent and source bank are captured at the request so a following
  // block can complete on the final read cycle without disturbing this replay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      rd_shift <= '0;
    end else begin
      state <= state_next;
      if (rd_start) begin
        rd_cnt   <= '0;
        rd_bank  <= wr_bank;
        rd_shift <= blk_min;
      end else if (state == S_READ) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_shift <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (state == S_READ) begin
      out_valid <= 1'b1;
      out_re    <= rd_word[2*INPUT_WIDTH-1:INPUT_WIDTH];
      out_im    <= rd_word[INPUT_WIDTH-1:0];
      out_shift <= rd_shift;
      out_first <= (rd_cnt == '0);
      out_last  <= (rd_cnt == LAST);
    end else begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_shift <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  a_no_overrun: assert property (@(posedge clk) disable iff (rst)
    !(blk_done && (state == S_READ) && (rd_cnt != LAST)));

endmodule

// File: tb/tb_cbfp1_shift_detect.sv
// Bench for cbfp1_shift_detect: directed and randomized blocks checked every
// cycle against a block-level model of exponent and replay timing.
module tb_cbfp1_shift_detect;
  localparam int W  = 25;
  localparam int SW = 5;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_re, in_im;
  logic          out_valid;
  logic [W-1:0]  out_re, out_im;
  logic [SW-1:0] out_shift;
  logic          out_first, out_last;

  cbfp1_shift_detect #(.INPUT_WIDTH(W), .SHIFT_WIDTH(SW), .BLOCK_LEN(BL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_shift(out_shift),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [SW-1:0] sh;
    bit            first;
    bit            last;
    int            cyc;
  } exp_t;

  exp_t          expq[$];
  int            blk_re[$];
  int            blk_im[$];
  logic [SW-1:0] lit[$] = '{5'd24, 5'd20, 5'd0, 5'd3, 5'd12};
  int            cyc = 0;
  int            checks = 0;
  int            passes = 0;
  bit            end_check = 1'b0;

  always @(posedge clk) cyc++;

  // Sign-bit redundancy from the magnitude's bit length.
  function automatic int rsb_m(int v);
    int m, bl;
    m  = (v < 0) ? -v - 1 : v;
    bl = 0;
    while (m > 0) begin
      m = m >> 1;
      bl++;
    end
    return (W - 1) - bl;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, req);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   ev;
    int   m;
    if (cyc == 1) begin
      chk("rsb_model_0",     64'(rsb_m(0)), 64'd24);
      chk("rsb_model_m1",    64'(rsb_m(-1)), 64'd24);
      chk("rsb_model_4095",  64'(rsb_m(4095)), 64'd12);
      chk("rsb_model_m4096", 64'(rsb_m(-4096)), 64'd12);
      chk("rsb_model_min",   64'(rsb_m(-(1 << 24))), 64'd0);
      chk("rsb_model_15",    64'(rsb_m(15)), 64'd20);
      chk("rsb_model_2p20",  64'(rsb_m(1 << 20)), 64'd3);
    end
    ev = !rst && (expq.size() > 0) && (expq[0].cyc == cyc);
    e.re = '0; e.im = '0; e.sh = '0; e.first = 1'b0; e.last = 1'b0; e.cyc = 0;
    if (ev) e = expq.pop_front();
    chk("outputs", 64'({out_valid, out_re, out_im, out_shift, out_first, out_last}),
        64'({ev, e.re, e.im, e.sh, e.first, e.last}));
    if (ev && e.first && lit.size() > 0) chk("directed_shift", 64'(out_shift), 64'(lit.pop_front()));
    if (end_check) chk("drained", 64'(expq.size()), 64'd0);

    // The next rising edge is number cyc+1; a block completing there replays from cyc+2.
    if (rst) begin
      expq.delete();
      blk_re.delete();
      blk_im.delete();
    end else if (in_valid) begin
      blk_re.push_back(int'($signed(in_re)));
      blk_im.push_back(int'($signed(in_im)));
      if (blk_re.size() == BL) begin
        m = W - 1;
        for (int k = 0; k < BL; k++) begin
          if (rsb_m(blk_re[k]) < m) m = rsb_m(blk_re[k]);
          if (rsb_m(blk_im[k]) < m) m = rsb_m(blk_im[k]);
        end
        for (int k = 0; k < BL; k++) begin
          e.re = W'(blk_re[k]); e.im = W'(blk_im[k]); e.sh = SW'(m);
          e.first = (k == 0); e.last = (k == BL - 1); e.cyc = cyc + 2 + k;
          expq.push_back(e);
        end
        blk_re.delete();
        blk_im.delete();
      end
    end
  end

  task automatic send(int re, int im);
    in_valid = 1'b1;
    in_re    = W'(re);
    in_im    = W'(im);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && expq.size() > 0; i++) idle(1);
    idle(2);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  function automatic int rnd();
    int v;
    v = $urandom;
    return v >>> $urandom_range(31, 7);
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
    idle(3);
    rst = 1'b0;
    idle(2);

    for (int k = 0; k < BL; k++) send(0, 0);
    drain();
    for (int k = 0; k < BL; k++) send(k, 0);
    drain();
    for (int k = 0; k < BL; k++) send((k == 7) ? -(1 << 24) : 1, 0);
    drain();
    for (int k = 0; k < BL; k++) send(1, (k == 3) ? (1 << 20) : 0);
    for (int k = 0; k < BL; k++) send((k % 2 == 0) ? 4095 : -4096, (k % 2 == 0) ? -4096 : 4095);
    drain();

    for (int b = 0; b < 8; b++)
      for (int k = 0; k < BL; k++) begin
        while ($urandom_range(1) == 1) idle(1);
        send(rnd(), rnd());
      end
    drain();

    for (int k = 0; k < 9; k++) send(-(1 << 24), 1 << 23);
    pulse_reset();
    for (int k = 0; k < BL; k++) send(rnd(), rnd());
    idle(5);
    pulse_reset();
    for (int k = 0; k < BL; k++) send(100 + k, -3 * k);
    drain();

    end_check = 1'b1;
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of stimulus, want finish");
    $fatal(1);
  end
endmodule

// File: doc/cbfp1_shift_detect.md
Name: cbfp1_shift_detect

Overview:
- Producer of the CBFP stage-1 normalisation shift consumed by the bit-shift/normaliser.
- Buffers complex 25-bit butterfly outputs in fixed-length blocks.
- Computes the block exponent: the minimum count of redundant sign bits over all real and imaginary parts in the block.
- Replays the buffered block with that exponent attached to every sample, using ping-pong banks for continuous streaming.

Parameters:
- INPUT_WIDTH, 25, signed sample width of re/im.
- SHIFT_WIDTH, 5, width of the shift value.
- BLOCK_LEN, 16, samples per CBFP block; power of two, ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample strobe; no backpressure.
- in_re  in  INPUT_WIDTH  signed real part.
- in_im  in  INPUT_WIDTH  signed imaginary part.
- out_valid  out  1  output sample strobe.
- out_re  out  INPUT_WIDTH  buffered real part, unmodified.
- out_im  out  INPUT_WIDTH  buffered imaginary part, unmodified.
- out_shift  out  SHIFT_WIDTH  block exponent, constant across a block.
- out_first  out  1  high with the first sample of each output block.
- out_last  out  1  high with the last sample of each output block.

Behaviour:
- Reset (async assert, synchronous deassert use): all outputs 0, write/read counters 0, bank select 0, FSM IDLE, running minimum preset to INPUT_WIDTH-1. Any partial block in flight is discarded.
- rsb(x): count of bits below the MSB equal to the MSB. Range 0..INPUT_WIDTH-1.
  - rsb(0) = rsb(-1) = 24.
  - rsb(4095) = 12; rsb(-4096) = 12; rsb(-2^24) = 0.
- Write side:
  - Each in_valid cycle writes {re, im} to the write bank at address wr_cnt and increments wr_cnt.
  - Running minimum updated with min(rsb(re), rsb(im)), combined with the current sample in the same cycle.
  - Gaps in in_valid are allowed; the counter and minimum hold during gaps.
- Block completion (wr_cnt = BLOCK_LEN-1 with in_valid):
  - Latch final minimum into the block exponent register.
  - Swap banks; wr_cnt wraps to 0; running minimum presets to 24 for the next block.
  - Issue a read request.
- Read FSM:
  - IDLE: on read request -> READ, rd_cnt = 0.
  - READ: one sample per cycle, no gaps, BLOCK_LEN cycles.
  - At rd_cnt = BLOCK_LEN-1: -> IDLE, or stay in READ with rd_cnt = 0 if a new request arrives in the same cycle, giving back-to-back out_valid.
- Latency:
  - out_valid for the first sample is registered on the edge after the edge that accepted the last input sample of the block.
  - With continuous input, a sample reappears BLOCK_LEN+1 cycles after entry.
- Output timing:
  - Outputs are registered; out_re/out_im/out_shift/out_first/out_last are valid only with out_valid.
  - Otherwise they hold 0.
- Overflow cannot occur: the next block needs ≥BLOCK_LEN input cycles, and the read of the current block finishes in BLOCK_LEN cycles.
  - Simulation assertion: read request while in READ with rd_cnt ≠ BLOCK_LEN-1 is an error.
- Reset mid-read: output stops immediately (out_valid 0 on reset); the pending block is lost.
- Downstream contract: out_shift feeds SHIFT_TARGET=13 normalisation. shift = rsb guarantees (x <<< shift) >>> 13 fits 12 signed bits.

Test Plan:
- All-zero block, continuous valid: 16 outputs re=im=0, out_shift=24; out_first on output 0, out_last on output 15; first out_valid exactly 1 cycle after 16th input.
- Block with re[k]=k (0..15), im=0: shift=20, since rsb(15)=20; data replayed in order bit-exact.
- Block all re=1 except re[7]=-2^24: out_shift=0 on all 16 outputs.
- Block with re=1, im[3]=2^20, others 0: shift=3 (imag dominates). Next block all 4095/-4096: shift=12; the two blocks are back-to-back with no out_valid gap.
- Input with random in_valid gaps (≈50% duty) over 8 blocks: each output block contiguous 16 cycles; exponents match reference model; the assertion never fires.
- Reset asserted after 9 samples of block 0 and again during replay of a complete block: outputs 0 immediately. The next full block after release yields a correct exponent with no contamination from pre-reset samples.
